program_counter: RTL and testbench

Fetch-stage program counter for the 32-bit RISC-V core. Holds the address of the instruction being fetched. Each cycle it advances by 4 or redirects to a branch/jump target supplied by execute. Also supplies the combinational next-PC and PC+4 to fetch and the link-address logic.

---
 rtl/program_counter_if.sv | 37 +++
 rtl/program_counter.sv | 53 +++++
 tb/tb_program_counter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/program_counter_if.sv
// Fetch-side bundle for the program counter: redirect/stall controls in, PC values out.
// Trap redirect signals exist only when PC_TRAP_EN is defined.
interface program_counter_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
`ifdef PC_TRAP_EN
  logic            trap_taken;
  logic [XLEN-1:0] trap_vector;
`endif
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_next;
  logic            misaligned;

`ifdef PC_TRAP_EN
  modport master (
    output stall, branch_taken, branch_target, trap_taken, trap_vector,
    input  pc_out, pc_plus4, pc_next, misaligned
  );
  modport slave (
    input  stall, branch_taken, branch_target, trap_taken, trap_vector,
    output pc_out, pc_plus4, pc_next, misaligned
  );
`else
  modport master (
    output stall, branch_taken, branch_target,
    input  pc_out, pc_plus4, pc_next, misaligned
  );
  modport slave (
    input  stall, branch_taken, branch_target,
    output pc_out, pc_plus4, pc_next, misaligned
  );
`endif
endinterface

// File: rtl/program_counter.sv
// Fetch-stage program counter: advances by PC_STEP, holds on stall, redirects on branch.
// Optional macro PC_TRAP_EN adds a highest-priority trap redirect.
module program_counter #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4
) (
  input logic              clk,
  input logic              rst,
  program_counter_if.slave pc_if
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            misaligned_q;
  logic            misaligned_d;
  logic [XLEN-1:0] pc_plus_step;

  assign pc_plus_step = pc_q + XLEN'(PC_STEP);

  // Redirect targets are forced word-aligned; only branch misalignment is flagged.
  always_comb begin
    pc_d         = pc_plus_step;
    misaligned_d = 1'b0;
`ifdef PC_TRAP_EN
    if (pc_if.trap_taken) begin
      pc_d = {pc_if.trap_vector[XLEN-1:2], 2'b00};
    end else
`endif
    if (pc_if.branch_taken) begin
      pc_d         = {pc_if.branch_target[XLEN-1:2], 2'b00};
      misaligned_d = (pc_if.branch_target[1:0] != 2'b00);
    end else if (pc_if.stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_if.pc_out     = pc_q;
  assign pc_if.pc_plus4   = pc_plus_step;
  assign pc_if.pc_next    = pc_d;
  assign pc_if.misaligned = misaligned_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by random
// stall/branch/reset traffic, all checked against a next-address reference model.
module tb_program_counter;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;

  logic clk;
  logic rst;

  program_counter_if #(.XLEN(XLEN)) pcIf ();

  program_counter #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RV),
    .PC_STEP     (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pc_if(pcIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          compared;
  int          mismatched;
  logic [31:0] modelPc;
  logic        modelMis;

  // Next address from the priority rules, computed on plain integers.
  function automatic logic [31:0] refNext(input logic [31:0] pc, input logic stl, input logic br,
                                          input logic [31:0] tgt, input logic tr, input logic [31:0] tv);
    longint unsigned sum;
`ifdef PC_TRAP_EN
    if (tr) return (tv / 4) * 4;
`endif
    if (br) return (tgt / 4) * 4;
    if (stl) return pc;
    sum = longint'(pc) + 4;
    return 32'(sum % 64'h1_0000_0000);
  endfunction

  function automatic logic refMis(input logic br, input logic [31:0] tgt, input logic tr);
`ifdef PC_TRAP_EN
    if (tr) return 1'b0;
`endif
    return br && ((tgt % 4) != 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic stallV, input logic brV,
                               input logic [31:0] tgtV, input logic trV, input logic [31:0] tvV);
    logic [31:0] expNext;
    logic        expMis;
    rst                = rstV;
    pcIf.stall         = stallV;
    pcIf.branch_taken  = brV;
    pcIf.branch_target = tgtV;
`ifdef PC_TRAP_EN
    pcIf.trap_taken    = trV;
    pcIf.trap_vector   = tvV;
`endif
    if (!rstV) begin
      modelPc  = RV;
      modelMis = 1'b0;
    end
    #1;
    expNext = refNext(modelPc, stallV, brV, tgtV, trV, tvV);
    expMis  = refMis(brV, tgtV, trV);
    checkOutput("pc_plus4", pcIf.pc_plus4, 32'(longint'(modelPc) + 4));
    checkOutput("pc_next", pcIf.pc_next, expNext);
    @(posedge clk);
    if (rstV) begin
      modelPc  = expNext;
      modelMis = expMis;
    end
    @(negedge clk);
    checkOutput("pc_out", pcIf.pc_out, modelPc);
    checkOutput("misaligned", {31'b0, pcIf.misaligned}, {31'b0, modelMis});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    modelPc    = RV;
    modelMis   = 1'b0;
    rst        = 1'b0;
    pcIf.stall         = 1'b0;
    pcIf.branch_taken  = 1'b0;
    pcIf.branch_target = '0;
`ifdef PC_TRAP_EN
    pcIf.trap_taken    = 1'b0;
    pcIf.trap_vector   = '0;
`endif
    #1;
    checkOutput("reset_pc", pcIf.pc_out, RV);
    checkOutput("reset_mis", {31'b0, pcIf.misaligned}, 32'd0);

    // Held in reset for two edges, then count up.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("reset_hold", pcIf.pc_out, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("count_16", pcIf.pc_out, 32'd16);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

    // One-cycle redirect to 100 from 20.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd100, 1'b0, 32'd0);
    checkOutput("branch_100", pcIf.pc_out, 32'd100);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("after_branch_108", pcIf.pc_out, 32'd108);

    // Misaligned redirect to 114 lands on 112 with the flag, then async reset mid-cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd114, 1'b0, 32'd0);
    checkOutput("mis_112", pcIf.pc_out, 32'd112);
    #2 rst = 1'b0;
    #1;
    modelPc  = RV;
    modelMis = 1'b0;
    checkOutput("async_reset_pc", pcIf.pc_out, RV);
    checkOutput("async_reset_mis", {31'b0, pcIf.misaligned}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("restart_8", pcIf.pc_out, 32'd8);

    // Stall holds; redirect beats stall.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("stall_hold", pcIf.pc_out, 32'd8);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd64, 1'b0, 32'd0);
    checkOutput("stall_branch_64", pcIf.pc_out, 32'd64);

    // Misaligned target 102: one-cycle flag.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd102, 1'b0, 32'd0);
    checkOutput("mis_pc_100", pcIf.pc_out, 32'd100);
    checkOutput("mis_set", {31'b0, pcIf.misaligned}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("mis_clear", {31'b0, pcIf.misaligned}, 32'd0);

    // Held redirect reloads every cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
    checkOutput("held_branch", pcIf.pc_out, 32'h40);

    // Wrap-around at the top of the address space.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    checkOutput("wrap_0", pcIf.pc_out, 32'd0);
    checkOutput("wrap_no_flag", {31'b0, pcIf.misaligned}, 32'd0);

`ifdef PC_TRAP_EN
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h103, 1'b1, 32'h200);
    checkOutput("trap_200", pcIf.pc_out, 32'h200);
    checkOutput("trap_no_flag", {31'b0, pcIf.misaligned}, 32'd0);
`endif

    // Random traffic, with occasional reset cycles.
    for (int i = 0; i < 400; i++) begin
      logic        rV, sV, bV, tV;
      logic [31:0] tg, tv;
      rV = ($urandom_range(0, 31) != 0);
      sV = ($urandom_range(0, 2) == 0);
      bV = ($urandom_range(0, 3) == 0);
      tV = ($urandom_range(0, 7) == 0);
      tg = $urandom;
      tv = $urandom;
      if ($urandom_range(0, 15) == 0) tg = 32'hFFFF_FFFC;
      applyStimulus(rV, sV, bV, tg, tV, tv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
